// File: rtl/blood_type_classification.sv
// Blood type classifier with per-type and rare-sample statistics.
//
// Each accepted sample (in_valid=1) is classified one cycle later on
// blood_output (1 = rare type), decoded one-hot on type_onehot, and flagged
// with out_valid. Eight saturating per-type counters and a saturating rare
// counter accumulate statistics; any per-type counter can be read
// combinationally through cnt_sel/cnt_value.
//
// Ports:
//   clk          : clock, all state updates on rising edge
//   rst          : synchronous active-high reset (clears outputs and counters)
//   bloodType    : 3-bit encoded blood type of the current sample
//   in_valid     : bloodType carries a sample this cycle
//   blood_output : registered rare flag of the last accepted sample
//   out_valid    : blood_output/type_onehot were updated this cycle
//   type_onehot  : registered one-hot decode of the last accepted bloodType
//   cnt_sel      : selects the per-type counter shown on cnt_value
//   cnt_value    : combinational read of the selected per-type counter
//   rare_count   : registered count of accepted rare samples
module blood_type_classification #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       bloodType,
    input  logic             in_valid,
    output logic             blood_output,
    output logic             out_valid,
    output logic [7:0]       type_onehot,
    input  logic [2:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_value,
    output logic [CNT_W-1:0] rare_count
);

    // Codes 001 (O+), 011 (A+) and 101 (B+) are the only common types.
    function automatic logic is_rare(input logic [2:0] code);
        return !(code == 3'd1 || code == 3'd3 || code == 3'd5);
    endfunction

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] type_cnt [8];

    // Stage boundary: sample accepted on this edge, results visible next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            blood_output <= 1'b0;
            out_valid    <= 1'b0;
            type_onehot  <= 8'h00;
            rare_count   <= '0;
            for (int i = 0; i < 8; i++) begin
                type_cnt[i] <= '0;
            end
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                blood_output        <= is_rare(bloodType);
                type_onehot         <= 8'b1 << bloodType;
                type_cnt[bloodType] <= sat_inc(type_cnt[bloodType]);
                if (is_rare(bloodType)) begin
                    rare_count <= sat_inc(rare_count);
                end
            end
        end
    end

    // Reads the registered value, so a same-edge increment appears only
    // after that edge.
    assign cnt_value = type_cnt[cnt_sel];

endmodule

// File: tb/tb_blood_type_classification.sv
module tb_blood_type_classification;

    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       bloodType = 3'd0;
    logic             in_valid = 1'b0;
    logic             blood_output;
    logic             out_valid;
    logic [7:0]       type_onehot;
    logic [2:0]       cnt_sel = 3'd0;
    logic [CNT_W-1:0] cnt_value;
    logic [CNT_W-1:0] rare_count;

    blood_type_classification #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bloodType    (bloodType),
        .in_valid     (in_valid),
        .blood_output (blood_output),
        .out_valid    (out_valid),
        .type_onehot  (type_onehot),
        .cnt_sel      (cnt_sel),
        .cnt_value    (cnt_value),
        .rare_count   (rare_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: unbounded counts, saturation applied on read.
    typedef struct {
        logic       rare;
        logic [7:0] onehot;
    } exp_t;
    exp_t exp_q[$];
    int   m_cnt[8];
    int   m_rare;
    logic m_last_rare;
    logic [7:0] m_last_onehot;
    int   rare_codes[$] = '{0, 2, 4, 6, 7};

    function automatic logic model_rare(input int code);
        foreach (rare_codes[i]) if (rare_codes[i] == code) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        m_rare = 0;
        m_last_rare = 1'b0;
        m_last_onehot = 8'h00;
        exp_q.delete();
    endtask

    // One clock: drive inputs away from the edge, then update the model
    // to reflect what that rising edge does.
    task automatic step(input logic v, input logic [2:0] c, input logic r);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        bloodType = c;
        rst       = r;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (v) begin
            m_cnt[c]++;
            e.rare   = model_rare(int'(c));
            e.onehot = 8'h01 << c;
            if (e.rare) m_rare++;
            m_last_rare   = e.rare;
            m_last_onehot = e.onehot;
            exp_q.push_back(e);
        end
    endtask

    task automatic check_counters(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        for (int s = 0; s < 8; s++) begin
            cnt_sel = 3'(s);
            #1;
            check($sformatf("%s cnt[%0d]", tag, s), int'(cnt_value), sat(m_cnt[s]));
        end
        check({tag, " rare_count"}, int'(rare_count), sat(m_rare));
    endtask

    // Monitor: pops expected responses whenever the DUT presents one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 || exp_q.size() != 0 || out_valid !== 1'b0) begin
                check("out_valid", int'(out_valid), int'(exp_q.size() != 0));
                if (out_valid === 1'b1 && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("blood_output", int'(blood_output), int'(e.rare));
                    check("type_onehot", int'(type_onehot), int'(e.onehot));
                end else begin
                    exp_q.delete();
                    check("hold blood_output", int'(blood_output), int'(m_last_rare));
                    check("hold type_onehot", int'(type_onehot), int'(m_last_onehot));
                end
                check("rare_count live", int'(rare_count), sat(m_rare));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        model_reset();
        step(1'b0, 3'd0, 1'b1);
        step(1'b1, 3'd5, 1'b1);
        check_counters("reset");
        tests++;
        if (blood_output !== 1'b0 || type_onehot !== 8'h00 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset outputs: got bo=%b oh=%h ov=%b expected 0/00/0",
                     blood_output, type_onehot, out_valid);
        end

        // Sweep all codes back to back.
        for (int c = 0; c < 8; c++) step(1'b1, 3'(c), 1'b0);
        check_counters("sweep");

        // Sample of 010 followed by idle cycles: outputs hold.
        step(1'b1, 3'd2, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 3'($urandom_range(0, 7)), 1'b0);
        check_counters("hold");

        // Alternating common types.
        step(1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, (i % 2 == 0) ? 3'd1 : 3'd5, 1'b0);
        check_counters("common");

        // Saturation of one counter and rare_count.
        step(1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b1, 3'd7, 1'b0);
        check_counters("saturate");

        // Reset in the same cycle as a sample.
        step(1'b1, 3'd0, 1'b1);
        check_counters("rst_prio");

        // Randomized traffic with occasional mid-stream resets.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 59) == 0));
            if (i % 100 == 99) check_counters("random");
        end
        step(1'b0, 3'd0, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        check_counters("final");
        check("queue drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/blood_type_classification.md
BLOOD_TYPE_CLASSIFICATION -- requirements
Module: blood_type_classification

Interface
REQ-001 Parameter CNT_W, default 8: width of each per-type sample counter and of the rare-sample counter.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port bloodType, input, 3: encoded blood type of the current sample.
REQ-005 Port in_valid, input, 1: bloodType carries a sample this cycle.
REQ-006 Port blood_output, output, 1: registered classification flag, 1 = rare type.
REQ-007 Port out_valid, output, 1: blood_output and type_onehot are updated this cycle.
REQ-008 Port type_onehot, output, 8: registered one-hot decode of the last accepted bloodType; bit i set for code i.
REQ-009 Port cnt_sel, input, 3: selects which per-type counter appears on cnt_value.
REQ-010 Port cnt_value, output, CNT_W: combinational read of the per-type counter selected by cnt_sel.
REQ-011 Port rare_count, output, CNT_W: registered count of accepted samples classified rare.

Function
REQ-012 The encoding SHALL be: 000 O-, 001 O+, 010 A-, 011 A+, 100 B-, 101 B+, 110 AB-, 111 AB+.
REQ-013 The rare set SHALL be: O-, A-, B-, AB-, AB+ (codes 000, 010, 100, 110, 111).
- Codes 001, 011 and 101 SHALL be common.
REQ-014 On a rising edge with in_valid=1 and rst=0, the block SHALL:
- set blood_output to 1 if bloodType is rare, else 0;
- set type_onehot to 1 << bloodType;
- set out_valid to 1.
- Latency from sample to outputs is exactly 1 cycle.
REQ-015 On a rising edge with in_valid=0 and rst=0:
- out_valid SHALL be 0;
- blood_output and type_onehot SHALL hold their previous values.
REQ-016 Back-to-back in_valid cycles SHALL each be accepted, with no bubbles and no backpressure.
REQ-017 Each accepted sample SHALL increment the per-type counter indexed by bloodType by 1.
REQ-018 Each accepted rare sample SHALL also increment rare_count by 1.
REQ-019 Every counter SHALL saturate at 2^CNT_W-1 and never wrap.
- Saturation of one counter SHALL not affect any other counter.
REQ-020 cnt_value SHALL reflect the selected counter's registered value in the same cycle cnt_sel changes.
- cnt_value SHALL not include the increment of a sample accepted on the same edge until after that edge.
REQ-021 All 8 bloodType codes SHALL be legal.
- No input value produces X on any output.

Reset
REQ-022 When rst=1 at a rising edge, the block SHALL clear:
- blood_output to 0, out_valid to 0, type_onehot to 8'h00;
- all eight per-type counters to 0;
- rare_count to 0.
REQ-023 rst SHALL take priority over in_valid.
- A sample presented in the reset cycle SHALL be discarded and not counted.
REQ-024 rst asserted mid-stream SHALL discard any pending statistics.
- The first accepted sample after rst deasserts SHALL behave as the first sample after power-up.

Verification
REQ-025 Reset, then drive bloodType 000..111, one per cycle, with in_valid=1 -> one cycle later blood_output SHALL follow the sequence 1,0,1,0,1,0,1,1, with out_valid=1 throughout.
REQ-026 After the REQ-025 sweep, cnt_sel 0..7 SHALL each read cnt_value=1, and rare_count SHALL read 5.
REQ-027 Hold in_valid=0 for 3 cycles after a sample of 010 -> blood_output SHALL stay 1, type_onehot SHALL stay 8'h04, out_valid SHALL be 0, and no counter SHALL change.
REQ-028 With CNT_W=8, feed 300 consecutive samples of 111 -> the counter for cnt_sel=7 SHALL read 255, rare_count SHALL read 255, and all other type counters SHALL read 0.
REQ-029 Assert rst in the same cycle as in_valid=1 with bloodType=000 -> the next cycle SHALL show all outputs at 0 and all counters at 0.
REQ-030 Feed alternating 001 and 101 for 10 samples -> blood_output SHALL stay 0, rare_count SHALL stay 0, and counters 1 and 5 SHALL each read 5.
